// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - Booth digit encoding and pipeline/tree sizing helpers
package mul_pkg;

  localparam int STAGES = 3;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_ONE  = 2'd1,
    SEL_TWO  = 2'd2
  } booth_sel_e;

  typedef struct packed {
    logic       neg;
    booth_sel_e sel;
  } booth_digit_t;

  function automatic int pp_count(input int width);
    return width / 2 + 1;
  endfunction

  // Overlapping triplet {y[2i+1], y[2i], y[2i-1]} -> digit in {0, +-1, +-2}
  function automatic booth_digit_t booth_decode(input logic [2:0] bits);
    booth_digit_t d;
    d.neg = 1'b0;
    d.sel = SEL_ZERO;
    case (bits)
      3'b001, 3'b010: d.sel = SEL_ONE;
      3'b011:         d.sel = SEL_TWO;
      3'b100: begin
        d.neg = 1'b1;
        d.sel = SEL_TWO;
      end
      3'b101, 3'b110: begin
        d.neg = 1'b1;
        d.sel = SEL_ONE;
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic int rows_next(input int rows);
    return 2 * (rows / 3) + rows % 3;
  endfunction

  function automatic int rows_at(input int rows, input int level);
    int c;
    c = rows;
    for (int i = 0; i < level; i++) c = rows_next(c);
    return c;
  endfunction

  function automatic int tree_depth(input int rows);
    int c;
    int d;
    c = rows;
    d = 0;
    while (c > 2) begin
      c = rows_next(c);
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// rtl/booth_pp_gen.sv - radix-4 Booth partial products plus negation correction bits
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PP_N  = pp_count(WIDTH)
) (
  input  logic [WIDTH+1:0]             xe,
  input  logic [WIDTH+1:0]             ye,
  output logic [PP_N-1:0][2*WIDTH-1:0] pp,
  output logic [PP_N-1:0]              neg
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    mx1;
  logic [PW-1:0]    mx2;
  logic [WIDTH+2:0] yb;

  assign mx1 = {{(PW - WIDTH - 2){xe[WIDTH+1]}}, xe};
  assign mx2 = mx1 << 1;
  assign yb  = {ye, 1'b0};

  // Negative digits use ~m here; the +1 is carried in neg[i] at bit 2i
  always_comb begin
    booth_digit_t d;
    logic [PW-1:0] m;
    d   = '0;
    m   = '0;
    pp  = '0;
    neg = '0;
    for (int i = 0; i < PP_N; i++) begin
      d = booth_decode(yb[2*i +: 3]);
      case (d.sel)
        SEL_ONE: m = mx1;
        SEL_TWO: m = mx2;
        default: m = '0;
      endcase
      if (d.neg) m = ~m;
      pp[i]  = m << (2 * i);
      neg[i] = d.neg;
    end
  end

endmodule

// File: rtl/mul_pipe_hs.sv
// rtl/mul_pipe_hs.sv - three-stage Booth/Wallace multiplier with valid/ready, tag and flush
module mul_pipe_hs
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sign,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW    = 2 * WIDTH;
  localparam int PP_N  = pp_count(WIDTH);
  localparam int ROWS0 = PP_N + 1;
  localparam int DEPTH = tree_depth(ROWS0);

  logic v1, v2, v3;
  logic rdy1, rdy2, rdy3;

  // Ready ripples back so an empty stage fills even while the output stalls
  assign rdy3      = !v3 || out_ready;
  assign rdy2      = !v2 || rdy3;
  assign rdy1      = !v1 || rdy2;
  assign in_ready  = rdy1;
  assign out_valid = v3;

  logic [WIDTH+1:0]            xe, ye;
  logic [PP_N-1:0][PW-1:0]     pp_d, pp1;
  logic [PP_N-1:0]             neg_d, neg1;
  logic [TAG_W-1:0]            tag1, tag2;
  logic [PW-1:0]               corr1;
  logic [PW-1:0]               sum_d, carry_d, sum2, carry2;

  assign xe = {{2{sign & x[WIDTH-1]}}, x};
  assign ye = {{2{sign & y[WIDTH-1]}}, y};

  booth_pp_gen #(
    .WIDTH (WIDTH),
    .PP_N  (PP_N)
  ) u_pp_gen (
    .xe  (xe),
    .ye  (ye),
    .pp  (pp_d),
    .neg (neg_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (rdy1) v1 <= in_valid;
      if (rdy2) v2 <= v1;
      if (rdy3) v3 <= v2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pp1  <= '0;
      neg1 <= '0;
      tag1 <= '0;
    end else if (rdy1 && in_valid) begin
      pp1  <= pp_d;
      neg1 <= neg_d;
      tag1 <= in_tag;
    end
  end

  always_comb begin
    corr1 = '0;
    for (int i = 0; i < PP_N; i++) corr1[2*i] = neg1[i];
  end

  // Each level groups rows in threes through 3:2 compressors; leftovers pass through
  for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
    logic [PW-1:0] row [ROWS0];
    if (l == 0) begin : g_leaf
      for (genvar r = 0; r < ROWS0; r++) begin : g_row
        if (r < PP_N) begin : g_pp
          assign row[r] = pp1[r];
        end else begin : g_corr
          assign row[r] = corr1;
        end
      end
    end else begin : g_reduce
      localparam int RP = rows_at(ROWS0, l - 1);
      localparam int NG = RP / 3;
      localparam int RN = rows_at(ROWS0, l);
      for (genvar r = 0; r < ROWS0; r++) begin : g_row
        if (r < 2 * NG && r % 2 == 0) begin : g_sum
          assign row[r] = g_lvl[l-1].row[3*(r/2)]
                        ^ g_lvl[l-1].row[3*(r/2)+1]
                        ^ g_lvl[l-1].row[3*(r/2)+2];
        end else if (r < 2 * NG) begin : g_carry
          assign row[r] = ((g_lvl[l-1].row[3*(r/2)]   & g_lvl[l-1].row[3*(r/2)+1])
                         | (g_lvl[l-1].row[3*(r/2)]   & g_lvl[l-1].row[3*(r/2)+2])
                         | (g_lvl[l-1].row[3*(r/2)+1] & g_lvl[l-1].row[3*(r/2)+2])) << 1;
        end else if (r < RN) begin : g_pass
          assign row[r] = g_lvl[l-1].row[r + NG];
        end else begin : g_zero
          assign row[r] = '0;
        end
      end
    end
  end

  assign sum_d   = g_lvl[DEPTH].row[0];
  assign carry_d = g_lvl[DEPTH].row[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum2   <= '0;
      carry2 <= '0;
      tag2   <= '0;
    end else if (rdy2 && v1) begin
      sum2   <= sum_d;
      carry2 <= carry_d;
      tag2   <= tag1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result  <= '0;
      out_tag <= '0;
    end else if (rdy3 && v2) begin
      result  <= sum2 + carry2;
      out_tag <= tag2;
    end
  end

endmodule

// File: tb/tb_mul_pipe_hs.sv
// tb/tb_mul_pipe_hs.sv - scoreboard bench for mul_pipe_hs
module tb_mul_pipe_hs;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, sign, out_valid, out_ready;
  logic [W-1:0]  x, y;
  logic [TW-1:0] in_tag, out_tag;
  logic [PW-1:0] result;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [TW-1:0] tag;
    logic [PW-1:0] prod;
  } exp_t;

  exp_t          sbq[$];
  logic [TW-1:0] seen_tags[$];

  mul_pipe_hs #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .x         (x),
    .y         (y),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) sbq.delete();
    else begin
      if (out_valid && out_ready) begin
        seen_tags.push_back(out_tag);
        total_cnt++;
        if (sbq.size() == 0)
          $display("FAIL sb_unexpected: tag=%0d result=%h, required no result", out_tag, result);
        else begin
          e = sbq.pop_front();
          if (out_tag !== e.tag || result !== e.prod)
            $display("FAIL sb_result: tag=%0d result=%h, required tag=%0d result=%h", out_tag, result, e.tag, e.prod);
          else pass_cnt++;
        end
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready) begin
        e.tag  = in_tag;
        e.prod = ref_mul(sign, x, y);
        sbq.push_back(e);
      end
    end
  end

  task automatic drain();
    int g;
    g = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sbq.size() != 0 || out_valid === 1'b1) && g < 30) begin
      @(posedge clk); #1;
      g++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sign = 1'b0; x = '0; y = '0; in_tag = '0;
    @(posedge clk); #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (result !== '0) $display("FAIL rst_result: got %h, required 0", result);
    else pass_cnt++;
    total_cnt++;
    if (out_tag !== '0) $display("FAIL rst_out_tag: got %0d, required 0", out_tag);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_release: got in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic          s_v[5];
    logic [W-1:0]  xa[5], ya[5];
    logic [PW-1:0] ra[5];
    logic [TW-1:0] et;
    int            lat;
    s_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    xa  = '{32'd1314, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    ya  = '{32'd9999, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
    ra  = '{64'd13138686, 64'h0000_0000_0000_0001, 64'hFFFF_FFFE_0000_0001,
            64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sign = s_v[i]; x = xa[i]; y = ya[i];
      et = TW'(i + 1);
      in_tag = et; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      total_cnt++;
      if (lat !== 3) $display("FAIL dir_latency[%0d]: got %0d edges, required 3", i, lat);
      else pass_cnt++;
      total_cnt++;
      if (result !== ra[i]) $display("FAIL dir_result[%0d]: got %h, required %h", i, result, ra[i]);
      else pass_cnt++;
      total_cnt++;
      if (out_tag !== et) $display("FAIL dir_tag[%0d]: got %0d, required %0d", i, out_tag, et);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    seen_tags.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_tag = TW'(i);
      sign = 1'($urandom_range(0, 1)); x = $urandom; y = $urandom;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (seen_tags.size() !== 16) $display("FAIL b2b_throughput: got %0d results, required 16", seen_tags.size());
    else pass_cnt++;
    drain();
    total_cnt++;
    if (sbq.size() !== 0) $display("FAIL b2b_drain: got %0d pending, required 0", sbq.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int            sent, g;
    logic [PW-1:0] cap_res;
    seen_tags.delete();
    out_ready = 1'b0;
    sent = 0;
    cap_res = '0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (sent < 5); in_tag = TW'(sent);
      sign = 1'($urandom_range(0, 1)); x = $urandom | 32'h100; y = $urandom | 32'h3;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      if (c == 2) begin
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %b, required 0", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1 || out_tag !== 4'd0)
          $display("FAIL bp_head: got valid=%b tag=%0d, required 1/0", out_valid, out_tag);
        else pass_cnt++;
        cap_res = result;
      end else if (c > 2) begin
        total_cnt++;
        if (result !== cap_res || out_tag !== 4'd0)
          $display("FAIL bp_stable[%0d]: got %h tag %0d, required %h tag 0", c, result, out_tag, cap_res);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (sent !== 3) $display("FAIL bp_accepted: got %0d, required 3", sent);
    else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    g = 0;
    while (sent < 5 && g < 20) begin
      in_valid = 1'b1; in_tag = TW'(sent);
      x = $urandom; y = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      g++;
    end
    drain();
    total_cnt++;
    if (seen_tags.size() !== 5) $display("FAIL bp_count: got %0d, required 5", seen_tags.size());
    else pass_cnt++;
    for (int i = 0; i < 5 && i < seen_tags.size(); i++) begin
      total_cnt++;
      if (seen_tags[i] !== TW'(i)) $display("FAIL bp_order[%0d]: got %0d, required %0d", i, seen_tags[i], i);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    int bad;
    seen_tags.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_tag = TW'(8 + i);
      sign = 1'b0; x = $urandom; y = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_tag = 4'd11; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL flush_full_valid: got %b, required 0", out_valid);
    else pass_cnt++;
    in_valid = 1'b1; in_tag = 4'd12; flush = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL flush_after_valid: got %b, required 0", out_valid);
    else pass_cnt++;
    bad = 0;
    foreach (seen_tags[i]) if (seen_tags[i] >= 4'd8 && seen_tags[i] <= 4'd12) bad++;
    total_cnt++;
    if (bad !== 0) $display("FAIL flush_leak: got %0d flushed tags delivered, required 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    sign = 1'b0;
    in_valid = 1'b1; in_tag = 4'd5; x = 32'd3; y = 32'd5;
    @(posedge clk); #1;
    in_tag = 4'd6; x = 32'd4; y = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b1 || result !== 64'd15)
      $display("FAIL rmid_pre: got valid=%b result=%h, required 1/15", out_valid, result);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || result !== '0 || out_tag !== '0)
      $display("FAIL rmid_clear: got valid=%b result=%h tag=%0d, required 0/0/0", out_valid, result, out_tag);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rmid_no_partial: got %b, required 0", out_valid);
    else pass_cnt++;
    sign = 1'b1; x = 32'hFFFF_FFF9; y = 32'd6; in_tag = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if (lat !== 3 || result !== 64'hFFFF_FFFF_FFFF_FFD6 || out_tag !== 4'd3)
      $display("FAIL rmid_new_op: got lat=%0d result=%h tag=%0d, required 3/ffffffffffffffd6/3", lat, result, out_tag);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_random();
    int tag_n;
    tag_n = 0;
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      sign      = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: x = $urandom;
        1: x = 32'h8000_0000;
        2: x = 32'hFFFF_FFFF;
        default: x = $urandom_range(0, 15);
      endcase
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = 32'h8000_0000;
        2: y = 32'hFFFF_FFFF;
        default: y = $urandom_range(0, 15);
      endcase
      in_tag = TW'(tag_n);
      @(negedge clk);
      if (in_valid && in_ready) tag_n++;
      @(posedge clk); #1;
    end
    drain();
    total_cnt++;
    if (sbq.size() !== 0) $display("FAIL rand_drain: got %0d pending, required 0", sbq.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
